// File: rtl/gbf_pingpong_ctrl_if.sv
// Bus bundle between the ping-pong controller, its input stream, the two
// global-buffer RAM banks and the PE-array read consumer.
interface gbf_pingpong_ctrl_if #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5
);
  logic [ADDR_BITWIDTH:0]   cfg_len;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_BITWIDTH-1:0] in_data;
  logic [ADDR_BITWIDTH-1:0] wr_addr;
  logic [DATA_BITWIDTH-1:0] wr_data;
  logic                     b0_ena;
  logic                     b1_ena;
  logic                     wea;
  logic                     rd_en;
  logic [ADDR_BITWIDTH-1:0] rd_addr;
  logic                     rd_done;
  logic                     rd_avail;
  logic                     b0_enb;
  logic                     b1_enb;
  logic [ADDR_BITWIDTH-1:0] rd_ram_addr;
  logic [DATA_BITWIDTH-1:0] b0_dob;
  logic [DATA_BITWIDTH-1:0] b1_dob;
  logic [DATA_BITWIDTH-1:0] rd_data;
  logic                     rd_data_valid;
  logic [3:0]               bank_state;

  modport slave (
    input  cfg_len, in_valid, in_data, rd_en, rd_addr, rd_done, b0_dob, b1_dob,
    output in_ready, wr_addr, wr_data, b0_ena, b1_ena, wea, rd_avail,
           b0_enb, b1_enb, rd_ram_addr, rd_data, rd_data_valid, bank_state
  );

  modport master (
    output cfg_len, in_valid, in_data, rd_en, rd_addr, rd_done, b0_dob, b1_dob,
    input  in_ready, wr_addr, wr_data, b0_ena, b1_ena, wea, rd_avail,
           b0_enb, b1_enb, rd_ram_addr, rd_data, rd_data_valid, bank_state
  );
endinterface

// File: rtl/gbf_pingpong_ctrl.sv
// Ping-pong fill/drain controller for two negedge-clocked global-buffer banks.
// Fills alternate between banks; a bank is handed to the reader once full.
module gbf_pingpong_ctrl #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32
) (
  input  logic               clk,
  input  logic               rst,
  gbf_pingpong_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_st_e;

  localparam logic [ADDR_BITWIDTH:0]   LEN_MAX = (ADDR_BITWIDTH+1)'(DEPTH);
  localparam logic [ADDR_BITWIDTH:0]   LEN_ONE = (ADDR_BITWIDTH+1)'(1);
  localparam logic [ADDR_BITWIDTH-1:0] CNT_ONE = ADDR_BITWIDTH'(1);

  bank_st_e                 r_state [2];
  bank_st_e                 w_state_nxt [2];
  logic                     r_wr_bank, w_wr_bank_nxt;
  logic                     r_rd_bank, w_rd_bank_nxt;
  logic [ADDR_BITWIDTH-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [ADDR_BITWIDTH:0]   r_len_lat, w_len_lat_nxt;
  logic [ADDR_BITWIDTH:0]   w_len_cfg, w_len_cur;
  logic                     w_wr_open, w_rd_open;
  logic                     w_wr_fire, w_wr_last, w_rd_fire, w_rd_rel;
  logic [DATA_BITWIDTH-1:0] r_rd_data;
  logic                     r_rd_vld;

  // Transfer qualifiers; gated by rst so no RAM strobe fires while in reset.
  always_comb begin
    w_len_cfg = (io_bus.cfg_len == '0 || io_bus.cfg_len > LEN_MAX) ? LEN_MAX : io_bus.cfg_len;
    w_wr_open = (r_state[r_wr_bank] == ST_EMPTY) || (r_state[r_wr_bank] == ST_FILLING);
    w_rd_open = (r_state[r_rd_bank] == ST_FULL)  || (r_state[r_rd_bank] == ST_READING);
    w_wr_fire = io_bus.in_valid & w_wr_open & ~rst;
    w_rd_fire = io_bus.rd_en    & w_rd_open & ~rst;
    w_rd_rel  = io_bus.rd_done  & w_rd_open & ~rst;
    // First beat of a tile uses the fresh length so len==1 completes at once.
    w_len_cur = (r_state[r_wr_bank] == ST_EMPTY) ? w_len_cfg : r_len_lat;
    w_wr_last = w_wr_fire && ({1'b0, r_wr_cnt} == (w_len_cur - LEN_ONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_len_lat  <= LEN_MAX;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_len_lat  <= w_len_lat_nxt;
    end
  end

  // Write and read sides never target the same bank: a bank open for writing
  // is EMPTY/FILLING, one open for reading is FULL/READING.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    w_wr_bank_nxt  = r_wr_bank;
    w_rd_bank_nxt  = r_rd_bank;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_len_lat_nxt  = r_len_lat;
    if (w_wr_fire) begin
      if (r_state[r_wr_bank] == ST_EMPTY) w_len_lat_nxt = w_len_cfg;
      if (w_wr_last) begin
        w_state_nxt[r_wr_bank] = ST_FULL;
        w_wr_cnt_nxt           = '0;
        w_wr_bank_nxt          = ~r_wr_bank;
      end else begin
        w_state_nxt[r_wr_bank] = ST_FILLING;
        w_wr_cnt_nxt           = r_wr_cnt + CNT_ONE;
      end
    end
    if (w_rd_fire && r_state[r_rd_bank] == ST_FULL) w_state_nxt[r_rd_bank] = ST_READING;
    if (w_rd_rel) begin
      w_state_nxt[r_rd_bank] = ST_EMPTY;
      w_rd_bank_nxt          = ~r_rd_bank;
    end
  end

  // dob settles at the negedge inside the request cycle, so the bank
  // selected by the current rd_bank is captured on the closing posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_fire;
      if (w_rd_fire) r_rd_data <= r_rd_bank ? io_bus.b1_dob : io_bus.b0_dob;
    end
  end

  always_comb begin
    io_bus.in_ready      = w_wr_open;
    io_bus.b0_ena        = w_wr_fire & ~r_wr_bank;
    io_bus.b1_ena        = w_wr_fire &  r_wr_bank;
    io_bus.wea           = w_wr_fire;
    io_bus.wr_addr       = r_wr_cnt;
    io_bus.wr_data       = io_bus.in_data;
    io_bus.rd_avail      = w_rd_open;
    io_bus.b0_enb        = w_rd_fire & ~r_rd_bank;
    io_bus.b1_enb        = w_rd_fire &  r_rd_bank;
    io_bus.rd_ram_addr   = io_bus.rd_addr;
    io_bus.rd_data       = r_rd_data;
    io_bus.rd_data_valid = r_rd_vld;
    io_bus.bank_state    = {r_state[1], r_state[0]};
  end

endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
// Bench for gbf_pingpong_ctrl: directed vector table, hand-written read and
// long-tile sequences, then random traffic against a tile-level model.
module tb_gbf_pingpong_ctrl;
  localparam int DW = 512;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gbf_pingpong_ctrl_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus ();

  gbf_pingpong_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Two negedge-clocked simple dual-port banks, 1-cycle read.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(negedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (bus.b0_ena && bus.wea) mem0[bus.wr_addr] <= bus.wr_data;
      if (bus.b1_ena && bus.wea) mem1[bus.wr_addr] <= bus.wr_data;
      if (bus.b0_enb) bus.b0_dob <= mem0[bus.rd_ram_addr];
      if (bus.b1_enb) bus.b1_dob <= mem1[bus.rd_ram_addr];
    end
  end

  typedef struct {
    logic rst, iv, ren, rdn; logic [AW-1:0] ra;
    logic rdy, e0, e1; logic [AW-1:0] wa;
    logic g0, g1, av, dv; logic [3:0] bs;
  } vec_t;

  function automatic vec_t R(int rs, int iv, int ren, int rdn, int ra, int rdy, int e0, int e1,
                             int wa, int g0, int g1, int av, int dv, int bs);
    vec_t v;
    v.rst = 1'(rs);  v.iv = 1'(iv);  v.ren = 1'(ren); v.rdn = 1'(rdn); v.ra = AW'(ra);
    v.rdy = 1'(rdy); v.e0 = 1'(e0);  v.e1 = 1'(e1);   v.wa = AW'(wa);
    v.g0 = 1'(g0);   v.g1 = 1'(g1);  v.av = 1'(av);   v.dv = 1'(dv);   v.bs = 4'(bs);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] status();
    return {bus.in_ready, bus.b0_ena, bus.b1_ena, bus.wea, bus.b0_enb, bus.b1_enb,
            bus.rd_avail, bus.rd_data_valid, bus.bank_state};
  endfunction

  function automatic logic [DW-1:0] pat(int k);
    return {16{32'hD00D_0000 + 32'(k)}};
  endfunction

  task automatic do_reset(input bit clr);
    rst = 1'b1;
    ram_clr = clr;
    bus.in_valid = 1'b0; bus.rd_en = 1'b0; bus.rd_done = 1'b0; bus.rd_addr = '0;
    bus.in_data = '0; bus.cfg_len = 6'd4;
    repeat (2) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    rst = 1'b0;
  endtask

  // Tile-level reference: counts of completed and released tiles decide which
  // bank fills/drains next; bank contents kept as a plain array.
  int            m_done, m_rel, m_beats, m_len;
  bit            m_hr;
  logic          m_dv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_mem [2][DEPTH];

  function automatic int clamp_len(int x);
    return (x == 0 || x > DEPTH) ? DEPTH : x;
  endfunction

  function automatic logic [1:0] m_bank(int b);
    int occ = m_done - m_rel;
    int wb  = m_done % 2;
    int rb  = m_rel % 2;
    if (occ == 2 || (occ == 1 && b == rb)) return (b == rb && m_hr) ? 2'd3 : 2'd2;
    if (b == wb && m_beats > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic m_reset();
    m_done = 0; m_rel = 0; m_beats = 0; m_len = DEPTH; m_hr = 0; m_dv = 0; m_rd = '0;
  endtask

  vec_t          tbl[$];
  logic [DW-1:0] d;
  int            lens[10] = '{0, 1, 2, 3, 4, 7, 31, 32, 33, 63};

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
    do_reset(1'b1);

    //        rst iv ren rdn ra  rdy e0 e1 wa  g0 g1 av dv bs
    tbl.push_back(R(0, 1, 1, 1, 0,  1, 1, 0, 0,  0, 0, 0, 0, 4'b0000));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 1,  0, 0, 0, 0, 4'b0001));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 2,  0, 0, 0, 0, 4'b0001));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 3,  0, 0, 0, 0, 4'b0001));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 0,  0, 0, 1, 0, 4'b0010));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 2,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 3,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 4'b1010));
    tbl.push_back(R(0, 1, 0, 1, 0,  0, 0, 0, 0,  0, 0, 1, 0, 4'b1010));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 1, 0, 4'b1000));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 1,  0, 0, 1, 0, 4'b1001));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 2,  0, 0, 1, 0, 4'b1001));
    tbl.push_back(R(0, 1, 1, 0, 0,  1, 1, 0, 3,  0, 1, 1, 0, 4'b1001));
    tbl.push_back(R(0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 1, 1, 4'b1110));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 0,  0, 0, 1, 0, 4'b0010));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 0, 1, 2,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 1, 0, 1, 0,  1, 0, 1, 3,  0, 0, 1, 0, 4'b0110));
    tbl.push_back(R(0, 0, 1, 0, 2,  1, 0, 0, 0,  0, 1, 1, 0, 4'b1000));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 1, 1, 4'b1100));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 1,  0, 0, 1, 0, 4'b1101));
    tbl.push_back(R(1, 1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 4'b0000));
    tbl.push_back(R(0, 1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      bus.in_valid = tbl[i].iv; bus.in_data = pat(i);
      bus.rd_en = tbl[i].ren; bus.rd_addr = tbl[i].ra; bus.rd_done = tbl[i].rdn;
      #1;
      chk($sformatf("tbl%0d status", i), DW'(status()),
          DW'({tbl[i].rdy, tbl[i].e0, tbl[i].e1, tbl[i].e0 | tbl[i].e1, tbl[i].g0, tbl[i].g1,
               tbl[i].av, tbl[i].dv, tbl[i].bs}));
      if (tbl[i].e0 || tbl[i].e1) begin
        chk($sformatf("tbl%0d wr_addr", i), DW'(bus.wr_addr), DW'(tbl[i].wa));
        chk($sformatf("tbl%0d wr_data", i), bus.wr_data, pat(i));
      end
      if (tbl[i].g0 || tbl[i].g1) chk($sformatf("tbl%0d rd_ram_addr", i), DW'(bus.rd_ram_addr), DW'(tbl[i].ra));
      @(posedge clk); #1;
    end

    // Read latency: fill bank0 with D0..D3, then four back-to-back reads.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in_data = pat(100 + k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.rd_en = 1'b1; bus.rd_addr = AW'(k);
      #1;
      chk($sformatf("rdseq%0d enb", k), DW'({bus.b0_enb, bus.b1_enb}), DW'(2'b10));
      chk($sformatf("rdseq%0d addr", k), DW'(bus.rd_ram_addr), DW'(k));
      chk($sformatf("rdseq%0d valid", k), DW'(bus.rd_data_valid), DW'(k > 0));
      chk($sformatf("rdseq%0d data", k), bus.rd_data, (k > 0) ? pat(99 + k) : '0);
      if (k == 1) chk("rdseq bank_state", DW'(bus.bank_state), DW'(4'b0011));
      @(posedge clk); #1;
    end
    bus.rd_en = 1'b0;
    #1;
    chk("rdseq last valid", DW'(bus.rd_data_valid), DW'(1));
    chk("rdseq last data", bus.rd_data, pat(103));
    chk("rdseq idle enb", DW'({bus.b0_enb, bus.b1_enb}), DW'(0));
    @(posedge clk); #1;
    chk("rdseq hold valid", DW'(bus.rd_data_valid), DW'(0));
    chk("rdseq hold data", bus.rd_data, pat(103));

    // cfg_len=0 means a full 32-word tile; a mid-fill length change is ignored.
    do_reset(1'b0);
    bus.cfg_len = 6'd0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = pat(200 + k);
      if (k == 10) bus.cfg_len = 6'd2;
      #1;
      chk($sformatf("len32 beat%0d ena", k), DW'({bus.b0_ena, bus.b1_ena}), DW'(2'b10));
      chk($sformatf("len32 beat%0d addr", k), DW'(bus.wr_addr), DW'(k));
      if (k == DEPTH - 1) chk("len32 still filling", DW'(bus.bank_state), DW'(4'b0001));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #1;
    chk("len32 full", DW'(bus.bank_state), DW'(4'b0010));

    // Random traffic against the tile-level model.
    do_reset(1'b1);
    m_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
    for (int c = 0; c < 4000; c++) begin
      int occ, wb, rb;
      bit fire, rf, rr;
      logic [1:0] b0s, b1s;
      rst = ($urandom_range(0, 299) == 0);
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
      bus.in_data = d;
      bus.in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) bus.cfg_len = 6'(lens[$urandom_range(0, 9)]);
      bus.rd_en = $urandom_range(0, 1) == 1;
      bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.rd_done = ($urandom_range(0, 9) == 0);
      #1;
      if (rst) m_reset();
      occ = m_done - m_rel;
      wb = m_done % 2;
      rb = m_rel % 2;
      fire = !rst && bus.in_valid && occ < 2;
      rf = !rst && bus.rd_en && occ > 0;
      rr = !rst && bus.rd_done && occ > 0;
      b0s = m_bank(0);
      b1s = m_bank(1);
      chk($sformatf("rnd%0d status", c), DW'(status()),
          DW'({occ < 2, fire && wb == 0, fire && wb == 1, fire, rf && rb == 0, rf && rb == 1,
               occ > 0, m_dv, b1s, b0s}));
      chk($sformatf("rnd%0d rd_data", c), bus.rd_data, m_rd);
      if (fire) begin
        chk($sformatf("rnd%0d wr_addr", c), DW'(bus.wr_addr), DW'(m_beats));
        chk($sformatf("rnd%0d wr_data", c), bus.wr_data, d);
      end
      if (rf) chk($sformatf("rnd%0d rd_ram_addr", c), DW'(bus.rd_ram_addr), DW'(bus.rd_addr));
      m_dv = rf;
      if (rf) begin
        m_hr = 1;
        m_rd = m_mem[rb][bus.rd_addr];
      end
      if (fire) begin
        if (m_beats == 0) m_len = clamp_len(int'(bus.cfg_len));
        m_mem[wb][m_beats] = d;
        m_beats++;
        if (m_beats == m_len) begin
          m_done++;
          m_beats = 0;
        end
      end
      if (rr) begin
        m_rel++;
        m_hr = 0;
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gbf_pingpong_ctrl.md
Name: gbf_pingpong_ctrl

Overview:
Ping-pong controller placed in front of a pair of global-buffer simple dual-port RAM banks (gbf buf1/buf2, 512b x 32, negedge-clocked, 1-cycle read). It accepts a valid/ready input stream of tile words and writes each tile into whichever bank is free. It hands full banks to the downstream PE-array loader through a read port with fixed latency. It tracks the state of each bank so fills and drains overlap without overwriting data that has not been read.

Parameters:
DATA_BITWIDTH, 512, word width (matches RAM dia/dob)
ADDR_BITWIDTH, 5, RAM address width
DEPTH, 32, words per bank

Ports:
clk  in  1  system clock (controller posedge; RAMs negedge)
rst  in  1  asynchronous, active-high reset
cfg_len  in  ADDR_BITWIDTH+1  words per tile; 0 or >DEPTH means DEPTH
in_valid  in  1  input word valid
in_ready  out  1  controller can accept the word
in_data  in  DATA_BITWIDTH  input word
wr_addr  out  ADDR_BITWIDTH  shared addra to both banks
wr_data  out  DATA_BITWIDTH  shared dia to both banks
b0_ena  out  1  bank0 port-A enable
b1_ena  out  1  bank1 port-A enable
wea  out  1  write enable to both banks (= b0_ena|b1_ena)
rd_en  in  1  read request from the consumer
rd_addr  in  ADDR_BITWIDTH  read address within the current read bank
rd_done  in  1  pulse: consumer releases the current read bank
rd_avail  out  1  current read bank is FULL or READING
b0_enb  out  1  bank0 port-B enable
b1_enb  out  1  bank1 port-B enable
rd_ram_addr  out  ADDR_BITWIDTH  shared addrb
b0_dob  in  DATA_BITWIDTH  bank0 read data
b1_dob  in  DATA_BITWIDTH  bank1 read data
rd_data  out  DATA_BITWIDTH  registered read data
rd_data_valid  out  1  rd_data is valid this cycle
bank_state  out  4  {bank1[1:0], bank0[1:0]}: 0=EMPTY, 1=FILLING, 2=FULL, 3=READING

Behaviour:
- Reset (async, rst=1): both banks EMPTY; wr_bank=0, rd_bank=0; wr_cnt=0; len_lat=DEPTH; rd_data=0; rd_data_valid=0. All combinational RAM strobes evaluate to 0. RAM contents are not cleared; data from a fill interrupted by reset is discarded.
- Write side:
  - in_ready = state[wr_bank] is EMPTY or FILLING.
  - A beat transfers when in_valid & in_ready. In that same cycle, bX_ena=1 for X=wr_bank, wea=1, wr_addr=wr_cnt, wr_data=in_data. These are combinational; the RAM captures them at the negedge of the same cycle.
  - First beat into an EMPTY bank: latch len_lat from cfg_len (clamped) and move the bank to FILLING. cfg_len changes during a fill are ignored.
  - Beat with wr_cnt==len_lat-1: bank moves to FULL, wr_cnt returns to 0, wr_bank toggles. For len_lat==1 the bank goes EMPTY->FULL directly.
  - Otherwise wr_cnt increments by 1.
- Read side:
  - rd_avail = state[rd_bank] is FULL or READING.
  - rd_en & rd_avail: bY_enb=1 for Y=rd_bank; rd_ram_addr=rd_addr (combinational); FULL moves to READING.
  - rd_en while !rd_avail is ignored: no enb, no valid.
  - Latency: the request in cycle N captures the bank select into a register. dob settles at the negedge of N. On the posedge ending N, rd_data is loaded with the selected bank's dob and rd_data_valid=1 for cycle N+1. Back-to-back requests give one word per cycle. rd_data holds its value when no request is accepted.
  - rd_done & rd_avail: bank moves to EMPTY and rd_bank toggles. rd_done while !rd_avail is ignored.
  - rd_en and rd_done in the same cycle: the read is served from the old bank (its data returns in N+1), then the bank is released.
- Simultaneous events:
  - The last write beat into bank X and rd_done on bank Y≠X in the same cycle are both applied. X becomes FULL, Y becomes EMPTY, and both pointers toggle.
  - The same bank can never be both FILLING and READING.
- Both banks FULL/READING: in_ready=0. Input is stalled until an rd_done; in_ready rises the cycle after that rd_done.
- rd_addr ≥ len_lat is not checked; the RAM returns stale contents.

Test Plan:
- cfg_len=4, 4 beats D0..D3 with in_valid held: b0_ena with wr_addr 0,1,2,3 → bank_state=4'b0010; next 4 beats go to b1_ena with addr 0..3 → bank_state=4'b1010.
- With both banks FULL, drive in_valid=1 → in_ready=0; issue rd_done → in_ready=1 next cycle; the next beat writes b0 at addr 0.
- Bank0 FULL with D0..D3; rd_en with rd_addr 0,1,2,3 on consecutive cycles → rd_data D0..D3 with rd_data_valid one cycle after each request; b0_enb only; bank0 becomes READING.
- Same cycle: last beat into bank1 plus rd_done on bank0 → bank_state=4'b1000, wr_bank=0, rd_bank=1, rd_avail=1.
- cfg_len=0 → 32 beats complete the bank (wr_addr 0..31); changing cfg_len to 2 mid-fill has no effect.
- rst asserted after 2 of 4 beats → immediately in_ready=1, bank_state=0, rd_data_valid=0; the next fill starts at bank0 addr 0.
